// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Front-end sequencer: next-PC select, pipeline hold/flush control,
//            saturating stall/flush debug counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int REG_W     = 4,
    parameter int PC_STEP   = 1,
    parameter int FLUSH_LEN = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              ex_halt,
    input  logic              mem_wait,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_nop,
    output logic              if_id_nop,
    output logic              id_ex_nop,
    output logic              ex_mem_nop,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [2:0] c_flush_init = 3'(FLUSH_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_fcnt;
    logic [2:0]        w_fcnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_stall_evt;
    logic              w_flush_evt;
    logic              w_hazard;
    logic [ADDR_W-1:0] w_pc_inc;

    // R0 is hard-wired, so a load targeting it never creates a dependency
    assign w_hazard = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign w_pc_inc = pc_current + ADDR_W'(PC_STEP);

    always_comb begin
        pc_next     = w_pc_inc;
        pc_nop      = 1'b0;
        if_id_nop   = 1'b0;
        id_ex_nop   = 1'b0;
        ex_mem_nop  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_stall_evt = 1'b0;
        w_flush_evt = 1'b0;
        if (reset) begin
            pc_next = '0;
        end else begin
            case (r_state)
                ST_HALTED: begin
                    pc_next    = pc_current;
                    pc_nop     = 1'b1;
                    if_id_nop  = 1'b1;
                    id_ex_nop  = 1'b1;
                    ex_mem_nop = 1'b1;
                    halted     = 1'b1;
                end
                ST_FLUSH: begin
                    if (mem_wait) begin
                        pc_next     = pc_current;
                        pc_nop      = 1'b1;
                        if_id_nop   = 1'b1;
                        id_ex_nop   = 1'b1;
                        ex_mem_nop  = 1'b1;
                        w_stall_evt = 1'b1;
                    end else begin
                        id_ex_flush = 1'b1;
                        if (r_fcnt == 3'd0) begin
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_fcnt_nxt = r_fcnt - 3'd1;
                        end
                    end
                end
                default: begin
                    if (mem_wait) begin
                        pc_next     = pc_current;
                        pc_nop      = 1'b1;
                        if_id_nop   = 1'b1;
                        id_ex_nop   = 1'b1;
                        ex_mem_nop  = 1'b1;
                        w_stall_evt = 1'b1;
                    end else if (ex_halt) begin
                        pc_next     = pc_current;
                        pc_nop      = 1'b1;
                        if_id_flush = 1'b1;
                        w_state_nxt = ST_HALTED;
                    end else if (ex_branch_taken) begin
                        pc_next     = ex_branch_target;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_state_nxt = ST_FLUSH;
                        w_fcnt_nxt  = c_flush_init;
                        w_flush_evt = 1'b1;
                    end else if (w_hazard) begin
                        pc_next     = pc_current;
                        pc_nop      = 1'b1;
                        if_id_nop   = 1'b1;
                        id_ex_flush = 1'b1;
                        w_stall_evt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_fcnt      <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the fetch/decode/execute front end. Decides the next fetch address for the PC register and drives its nop (hold) input.
- Issues hold and flush controls to the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves, in priority order: memory-wait freezes, HALT, taken branches and load-use hazards.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- ADDR_W, 16, PC/address width
- REG_W, 4, register-index width
- PC_STEP, 1, sequential PC increment (word-addressed)
- FLUSH_LEN, 2, cycles the FLUSH state lasts after a taken branch (1..7)
- CNT_W, 16, width of the debug counters

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc_current  in  ADDR_W  PC register output
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_branch_target  in  ADDR_W  resolved target
- ex_halt  in  1  EX instruction is HALT
- mem_wait  in  1  data memory not ready
- pc_next  out  ADDR_W  PC register address_in
- pc_nop  out  1  PC register hold
- if_id_nop, id_ex_nop, ex_mem_nop  out  1  hold the pipeline register
- if_id_flush, id_ex_flush  out  1  load a bubble into the pipeline register
- halted  out  1  core is stopped
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- **Timing.** State and counters are registered. All other outputs are combinational from state and inputs, so control takes effect at the next clk edge.
- **States.**
  - RUN
  - FLUSH, with internal down-counter fcnt
  - HALTED
- **Reset.** Reset dominates everything.
  - On the reset edge: state=RUN, fcnt=0, counters=0.
  - While reset is high: pc_next=0, all nop/flush outputs=0, halted=0.
  - Reset asserted in any state, including FLUSH or HALTED, returns to RUN on the next edge.
- **Default (RUN, no event).** pc_next=pc_current+PC_STEP, computed modulo 2^ADDR_W (0xFFFF wraps to 0x0000). All nop/flush outputs are 0.
- **Priority in RUN**, highest first:
  1. **mem_wait=1.** pc_nop, if_id_nop, id_ex_nop and ex_mem_nop are 1; flushes are 0; pc_next=pc_current. The state is unchanged. Branch, halt and hazard inputs are ignored this cycle and re-evaluated when mem_wait drops. stall_cnt increments.
  2. **ex_halt=1.** pc_nop=1 and if_id_flush=1; pc_next=pc_current. Next state is HALTED.
  3. **ex_branch_taken=1.** pc_next=ex_branch_target, pc_nop=0, if_id_flush=1, id_ex_flush=1. Next state is FLUSH with fcnt=FLUSH_LEN-1. flush_cnt increments.
  4. **Load-use hazard.** Condition: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
     - pc_nop=1, if_id_nop=1, id_ex_flush=1; pc_next=pc_current.
     - Exactly one bubble; state stays RUN. stall_cnt increments.
     - The load moves to MEM on the next edge, so the condition clears by itself.
- **FLUSH.**
  - ex_branch_taken, ex_halt and the hazard check are suppressed, because the instructions in EX are bubbles.
  - mem_wait is still honoured: freeze as in RUN, and fcnt does not decrement.
  - Otherwise the pipeline runs with normal increment, id_ex_flush=1 and other flushes 0.
  - When fcnt==0, the next state is RUN; otherwise fcnt decrements.
  - With FLUSH_LEN=1, FLUSH still lasts one cycle.
- **HALTED.**
  - pc_nop=1, all nops=1, flushes=0, pc_next=pc_current, halted=1.
  - All inputs except reset are ignored. Only reset leaves this state.
- **Counters.** Both counters saturate at all-ones and never wrap.
- **Zero register.** ex_rd==0 never causes a stall (R0 is hard-wired).

Test Plan:
1. **Sequential fetch.** Release reset with pc_current=0x0010 and no events → pc_next=0x0011, pc_nop=0. With pc_current=0xFFFF → pc_next=0x0000.
2. **Load-use stall.** ex_mem_read=1, ex_rd=3, id_rs2=3, id_uses_rs2=1 → exactly one cycle of pc_nop=1, if_id_nop=1, id_ex_flush=1. stall_cnt=1. The same case with ex_rd=0 → no stall.
3. **Taken branch.** ex_branch_taken=1, target=0x0040 → pc_next=0x0040, if_id_flush=id_ex_flush=1. FLUSH then lasts 2 cycles with FLUSH_LEN=2. A spurious ex_branch_taken during FLUSH is ignored. flush_cnt=1.
4. **mem_wait priority.** mem_wait=1 together with ex_branch_taken=1 for 3 cycles → all nops=1, pc_next=pc_current, no flush, stall_cnt=3. On the cycle mem_wait drops → branch taken to its target.
5. **Halt and recovery.** ex_halt=1 → HALTED next cycle, halted=1, pc_nop=1. It persists despite branch and hazard inputs. Assert reset → RUN, halted=0, counters=0.
6. **Reset mid-FLUSH.** Assert reset during the first FLUSH cycle → next state RUN. Subsequent ex_branch_taken is honoured immediately.
